read_scoreboard_ctrl: RTL and testbench

- Issue controller for the register-read pipeline stage.
- Tracks in-flight writes to the 16 architectural GPRs using per-register pending counters.
- Each cycle it decides whether the decoded instruction may enter Read. Its issue decision drives Read's canReadIn. It also back-pressures decode and supports flush and drain.

---
 rtl/read_scoreboard_ctrl_pkg.sv | 28 ++
 rtl/read_scoreboard_ctrl_if.sv | 52 +++++
 rtl/read_scoreboard_ctrl_reg_pending_counter.sv | 61 ++++++
 rtl/read_scoreboard_ctrl.sv | 134 +++++++++++++
 tb/tb_read_scoreboard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/read_scoreboard_ctrl_pkg.sv
// Package for the register-read scoreboard controller.
// Holds the GPR count, the fixed RAX/RDX indices used by the IMUL/MUL
// destination pair, the GPR index type, the drain FSM states and a
// one-hot decode helper shared by the controller.
package read_pkg;

  localparam int NUM_GPRS = 16;

  typedef logic [3:0] gpr_idx_t;

  localparam gpr_idx_t REG_RAX = 4'd0;
  localparam gpr_idx_t REG_RDX = 4'd2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } sb_state_t;

  // One-hot mask selecting a single GPR.
  function automatic logic [NUM_GPRS-1:0] gpr_onehot(input gpr_idx_t idx);
    logic [NUM_GPRS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/read_scoreboard_ctrl_if.sv
// Interface bundling the decode, writeback, control and status signals of
// the read scoreboard controller.
//   master : decode/writeback side, drives the *In signals, observes *Out.
//   slave  : the controller, observes the *In signals, drives the *Out.
interface read_scoreboard_ctrl_if
  import read_pkg::*;
#(
  parameter int PERF_W = 32
) ();

  logic              decodeValidIn;
  gpr_idx_t          sourceReg1In;
  logic              sourceReg1ValidIn;
  gpr_idx_t          sourceReg2In;
  logic              sourceReg2ValidIn;
  gpr_idx_t          destRegIn;
  logic              destRegValidIn;
  logic              destRegisterSpecialValidIn;
  logic              downstreamReadyIn;
  logic              stallIn;
  logic              wb0ValidIn;
  gpr_idx_t          wb0RegIn;
  logic              wb1ValidIn;
  gpr_idx_t          wb1RegIn;
  logic              flushIn;
  logic              drainIn;
  logic              canReadOut;
  logic              stallOut;
  logic [NUM_GPRS-1:0] busyMaskOut;
  logic              drainedOut;
  logic              wbErrorOut;
  logic [PERF_W-1:0] stallCyclesOut;

  modport master (
    output decodeValidIn, sourceReg1In, sourceReg1ValidIn, sourceReg2In,
           sourceReg2ValidIn, destRegIn, destRegValidIn,
           destRegisterSpecialValidIn, downstreamReadyIn, stallIn,
           wb0ValidIn, wb0RegIn, wb1ValidIn, wb1RegIn, flushIn, drainIn,
    input  canReadOut, stallOut, busyMaskOut, drainedOut, wbErrorOut,
           stallCyclesOut
  );

  modport slave (
    input  decodeValidIn, sourceReg1In, sourceReg1ValidIn, sourceReg2In,
           sourceReg2ValidIn, destRegIn, destRegValidIn,
           destRegisterSpecialValidIn, downstreamReadyIn, stallIn,
           wb0ValidIn, wb0RegIn, wb1ValidIn, wb1RegIn, flushIn, drainIn,
    output canReadOut, stallOut, busyMaskOut, drainedOut, wbErrorOut,
           stallCyclesOut
  );

endinterface

// File: rtl/read_scoreboard_ctrl_reg_pending_counter.sv
// Pending-write counter for one GPR.
//   clk, reset_n : clock, synchronous active-low reset
//   inc          : an issued instruction writes this register
//   dec0, dec1   : writeback port 0 / 1 retires a write to this register
//   clear        : flush; zero the count and ignore inc/dec this cycle
//   count        : current number of in-flight writes
//   saturated    : count is all-ones; no further writes may issue
//   underflow    : this cycle's decrements exceed count+inc (clamped to 0)
module reg_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec0,
  input  logic             dec1,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             saturated,
  output logic             underflow
);

  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_down;

  // One extra bit so count+inc and dec0+dec1 compare without wrapping.
  // inc is never asserted while saturated, so w_up always fits in CNT_W.
  assign w_up      = {1'b0, r_count} + SUM_W'(inc);
  assign w_down    = SUM_W'(dec0) + SUM_W'(dec1);
  assign underflow = !clear && (w_down > w_up);
  assign saturated = &r_count;
  assign count     = r_count;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next = r_count;
    if (clear || (w_down > w_up)) begin
      w_next = '0;
    end else begin
      w_next = CNT_W'(w_up - w_down);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of block evaluation order.
  // NOTE: the per-register counters are reset explicitly; leftover pending
  // counts from before a reset would block issue forever.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/read_scoreboard_ctrl.sv
// Issue controller for the register-read pipeline stage.
// Tracks in-flight GPR writes with one pending counter per register and
// decides each cycle whether the decoded instruction may enter Read.
//   clk, reset_n : clock, synchronous active-low reset
//   sb (slave)   : decode sources/dest, downstream ready, external stall,
//                  two writeback ports, flush, drain request; outputs
//                  canReadOut, stallOut, busyMaskOut, drainedOut,
//                  sticky wbErrorOut and saturating stallCyclesOut.
module read_scoreboard_ctrl
  import read_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1,
  parameter int PERF_W    = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  read_scoreboard_ctrl_if.slave sb
);

  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0]    w_count [NUM_GPRS];
  logic [NUM_GPRS-1:0] w_sat;
  logic [NUM_GPRS-1:0] w_underflow;
  logic [NUM_GPRS-1:0] w_inc;
  logic [NUM_GPRS-1:0] w_busy;
  logic [NUM_GPRS-1:0] w_zero_next;
  logic [NUM_GPRS-1:0] w_wb0_mask;
  logic [NUM_GPRS-1:0] w_wb1_mask;
  logic [NUM_GPRS-1:0] w_dest_mask;
  logic [CNT_W-1:0]    w_src1_cnt;
  logic [CNT_W-1:0]    w_src2_cnt;
  logic                w_src1_ready;
  logic                w_src2_ready;
  logic                w_dest_blocked;
  logic                w_issue;
  logic                w_stall;

  sb_state_t           r_state;
  sb_state_t           w_state_next;
  logic                r_wb_error;
  logic [PERF_W-1:0]   r_stall_cycles;

  assign w_wb0_mask = sb.wb0ValidIn ? gpr_onehot(sb.wb0RegIn) : '0;
  assign w_wb1_mask = sb.wb1ValidIn ? gpr_onehot(sb.wb1RegIn) : '0;

  // The IMUL/MUL class writes the RDX:RAX pair and overrides destRegIn.
  always_comb begin
    w_dest_mask = '0;
    if (sb.destRegisterSpecialValidIn) begin
      w_dest_mask = gpr_onehot(REG_RAX) | gpr_onehot(REG_RDX);
    end else if (sb.destRegValidIn) begin
      w_dest_mask = gpr_onehot(sb.destRegIn);
    end
  end

  // A source with exactly one outstanding write that is retiring this cycle
  // can be forwarded; with both ports hitting it the count is inconsistent.
  assign w_src1_cnt   = w_count[sb.sourceReg1In];
  assign w_src2_cnt   = w_count[sb.sourceReg2In];
  assign w_src1_ready = !sb.sourceReg1ValidIn || (w_src1_cnt == '0) ||
                        (WB_BYPASS && (w_src1_cnt == CNT_W'(1)) &&
                         (w_wb0_mask[sb.sourceReg1In] ^ w_wb1_mask[sb.sourceReg1In]));
  assign w_src2_ready = !sb.sourceReg2ValidIn || (w_src2_cnt == '0) ||
                        (WB_BYPASS && (w_src2_cnt == CNT_W'(1)) &&
                         (w_wb0_mask[sb.sourceReg2In] ^ w_wb1_mask[sb.sourceReg2In]));

  assign w_dest_blocked = |(w_dest_mask & w_sat);

  // Issue is held off while reset is asserted so nothing is counted then.
  assign w_issue = reset_n && sb.decodeValidIn && (r_state == RUN) &&
                   !sb.flushIn && !sb.stallIn && sb.downstreamReadyIn &&
                   w_src1_ready && w_src2_ready && !w_dest_blocked;
  assign w_stall = sb.decodeValidIn && !w_issue;
  assign w_inc   = {NUM_GPRS{w_issue}} & w_dest_mask;

  for (genvar g = 0; g < NUM_GPRS; g++) begin : g_cnt
    reg_pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (w_inc[g]),
      .dec0      (w_wb0_mask[g]),
      .dec1      (w_wb1_mask[g]),
      .clear     (sb.flushIn),
      .count     (w_count[g]),
      .saturated (w_sat[g]),
      .underflow (w_underflow[g])
    );
    assign w_busy[g] = |w_count[g];
    // Register is zero after this edge: flushed, or retired (clamped) to 0.
    assign w_zero_next[g] = sb.flushIn ||
      ((SUM_W'(w_count[g]) + SUM_W'(w_inc[g])) <=
       (SUM_W'(w_wb0_mask[g]) + SUM_W'(w_wb1_mask[g])));
  end

  always_comb begin
    w_state_next = r_state;
    if (sb.flushIn && !sb.drainIn) begin
      w_state_next = RUN;
    end else begin
      unique case (r_state)
        RUN:     if (sb.drainIn)    w_state_next = DRAIN;
        DRAIN:   if (&w_zero_next)  w_state_next = DRAINED;
        DRAINED: if (!sb.drainIn)   w_state_next = RUN;
        default:                    w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_wb_error     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      if (|w_underflow) begin
        r_wb_error <= 1'b1;
      end
      if (w_stall && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign sb.canReadOut     = w_issue;
  assign sb.stallOut       = w_stall;
  assign sb.busyMaskOut    = w_busy;
  assign sb.drainedOut     = (r_state == DRAINED);
  assign sb.wbErrorOut     = r_wb_error;
  assign sb.stallCyclesOut = r_stall_cycles;

endmodule

// File: tb/tb_read_scoreboard_ctrl.sv
// Self-checking bench for read_scoreboard_ctrl: a hand-derived vector
// table walking the main scenarios, reset sequences, then randomized
// traffic compared against a counter-array reference model.
module tb_read_scoreboard_ctrl;
  import read_pkg::*;

  localparam int CNT_W  = 2;
  localparam int CMAX   = 3;
  localparam int PERF_W = 32;
  localparam int N_RAND = 3000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  read_scoreboard_ctrl_if #(.PERF_W(PERF_W)) sb ();

  read_scoreboard_ctrl #(
    .CNT_W(CNT_W), .WB_BYPASS(1'b1), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sb(sb)
  );

  typedef struct packed {
    logic dec; logic s1v; logic [3:0] s1; logic s2v; logic [3:0] s2;
    logic dv; logic [3:0] d; logic sp; logic ds; logic st;
    logic w0v; logic [3:0] w0; logic w1v; logic [3:0] w1;
    logic fl; logic dr;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        can;
    logic        stall;
    logic [15:0] busy;
    logic        drained;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  int     m_cnt [16];
  int     m_state;     // 0 run, 1 drain, 2 drained
  logic   m_err;
  longint m_sc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(int dec, int s1v, int s1, int s2v, int s2,
                               int dv, int d, int sp, int ds, int st,
                               int w0v, int w0, int w1v, int w1, int fl, int dr);
    stim_t s;
    s.dec = (dec != 0); s.s1v = (s1v != 0); s.s1 = 4'(s1);
    s.s2v = (s2v != 0); s.s2 = 4'(s2);  s.dv = (dv != 0); s.d = 4'(d);
    s.sp = (sp != 0);   s.ds = (ds != 0); s.st = (st != 0);
    s.w0v = (w0v != 0); s.w0 = 4'(w0);  s.w1v = (w1v != 0); s.w1 = 4'(w1);
    s.fl = (fl != 0);   s.dr = (dr != 0);
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0, 0,0, 0,0);
  endfunction

  task automatic add(input stim_t s, input int can, input int stl, input int busy,
                     input int drained, input int err);
    vec_t v;
    v.in = s; v.can = (can != 0); v.stall = (stl != 0); v.busy = 16'(busy);
    v.drained = (drained != 0); v.err = (err != 0);
    vecs.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    sb.decodeValidIn              = s.dec;
    sb.sourceReg1ValidIn          = s.s1v;
    sb.sourceReg1In               = s.s1;
    sb.sourceReg2ValidIn          = s.s2v;
    sb.sourceReg2In               = s.s2;
    sb.destRegValidIn             = s.dv;
    sb.destRegIn                  = s.d;
    sb.destRegisterSpecialValidIn = s.sp;
    sb.downstreamReadyIn          = s.ds;
    sb.stallIn                    = s.st;
    sb.wb0ValidIn                 = s.w0v;
    sb.wb0RegIn                   = s.w0;
    sb.wb1ValidIn                 = s.w1v;
    sb.wb1RegIn                   = s.w1;
    sb.flushIn                    = s.fl;
    sb.drainIn                    = s.dr;
  endtask

  // Hold reset across one edge with a decoded instruction present, then
  // check every output against its reset value and release.
  task automatic do_reset(input string tag);
    stim_t s;
    s = idle();
    s.dec = 1'b1;
    @(negedge clk);
    drive(s);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " rst can"},     32'(sb.canReadOut), 32'd0);
    check({tag, " rst stall"},   32'(sb.stallOut), 32'd1);
    check({tag, " rst busy"},    32'(sb.busyMaskOut), 32'd0);
    check({tag, " rst drained"}, 32'(sb.drainedOut), 32'd0);
    check({tag, " rst err"},     32'(sb.wbErrorOut), 32'd0);
    check({tag, " rst stallcyc"}, sb.stallCyclesOut, 32'd0);
    reset_n = 1'b1;
    drive(idle());
  endtask

  // ---------------- reference model ----------------
  function automatic int nmatch(stim_t s, int r);
    return ((s.w0v && int'(s.w0) == r) ? 1 : 0) + ((s.w1v && int'(s.w1) == r) ? 1 : 0);
  endfunction

  function automatic bit in_dest(stim_t s, int r);
    if (s.sp) return (r == 0) || (r == 2);
    if (s.dv) return int'(s.d) == r;
    return 1'b0;
  endfunction

  function automatic bit src_ok(stim_t s, bit used, int r);
    if (!used) return 1'b1;
    if (m_cnt[r] == 0) return 1'b1;
    return (m_cnt[r] == 1) && (nmatch(s, r) == 1);
  endfunction

  function automatic bit model_can(stim_t s, logic rn);
    bit blocked = 1'b0;
    for (int r = 0; r < 16; r++)
      if (in_dest(s, r) && m_cnt[r] == CMAX) blocked = 1'b1;
    return rn && s.dec && (m_state == 0) && !s.fl && !s.st && s.ds &&
           src_ok(s, s.s1v, int'(s.s1)) && src_ok(s, s.s2v, int'(s.s2)) && !blocked;
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_state = 0; m_err = 1'b0; m_sc = 0;
  endtask

  task automatic model_step(input stim_t s, input logic rn, input bit can, input bit stl);
    bit all_zero = 1'b1;
    int n;
    if (!rn) begin
      model_reset();
      return;
    end
    if (stl && m_sc < 64'hFFFF_FFFF) m_sc++;
    for (int r = 0; r < 16; r++) begin
      if (s.fl) begin
        m_cnt[r] = 0;
      end else begin
        n = m_cnt[r] + ((can && in_dest(s, r)) ? 1 : 0) - nmatch(s, r);
        if (n < 0) begin
          n = 0;
          m_err = 1'b1;
        end
        m_cnt[r] = n;
      end
      if (m_cnt[r] != 0) all_zero = 1'b0;
    end
    if (s.fl && !s.dr) m_state = 0;
    else if (m_state == 0 && s.dr) m_state = 1;
    else if (m_state == 1 && all_zero) m_state = 2;
    else if (m_state == 2 && !s.dr) m_state = 0;
  endtask

  function automatic int pick_wb_reg();
    int busy_q[$];
    for (int r = 0; r < 16; r++) if (m_cnt[r] != 0) busy_q.push_back(r);
    if (busy_q.size() > 0 && $urandom_range(0, 9) < 8)
      return busy_q[$urandom_range(0, busy_q.size() - 1)];
    return int'($urandom_range(0, 15));
  endfunction

  // ---------------- test ----------------
  initial begin
    int    exp_sc;
    bit    drain_hold;
    stim_t s;
    logic  rn;
    bit    e_can, e_stl;

    drive(idle());

    //     dec s1v s1 s2v s2 dv d sp ds st w0v w0 w1v w1 fl dr     can stl busy  drn err
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,0,0);
    // dest R3, dependent reader, bypass on writeback
    add(mk(1, 0,0, 0,0, 1,3, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,0);
    add(mk(1, 1,3, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,1,16'h0008,0,0);
    add(mk(1, 1,4, 1,3, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,1,16'h0008,0,0);
    add(mk(1, 1,3, 0,0, 0,0, 0, 1,0, 1,3,  0,0,  0,0), 1,0,16'h0008,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,0,0);
    // IMUL pair, retired by both ports at once
    add(mk(1, 0,0, 0,0, 0,0, 1, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 1,0,  1,2,  0,0), 0,0,16'h0005,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,0,0);
    // R5 saturation
    add(mk(1, 0,0, 0,0, 1,5, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,0);
    add(mk(1, 0,0, 0,0, 1,5, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0020,0,0);
    add(mk(1, 0,0, 0,0, 1,5, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0020,0,0);
    add(mk(1, 0,0, 0,0, 1,5, 0, 1,0, 0,0,  0,0,  0,0), 0,1,16'h0020,0,0);
    add(mk(1, 0,0, 0,0, 1,5, 0, 1,0, 1,5,  0,0,  0,0), 0,1,16'h0020,0,0);
    add(mk(1, 0,0, 0,0, 1,5, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0020,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 1,5,  1,5,  0,0), 0,0,16'h0020,0,0);
    add(mk(1, 1,5, 0,0, 0,0, 0, 1,0, 1,5,  0,0,  0,0), 1,0,16'h0020,0,0);
    // downstream not ready, external stall
    add(mk(1, 0,0, 0,0, 0,0, 0, 0,0, 0,0,  0,0,  0,0), 0,1,16'h0000,0,0);
    add(mk(1, 0,0, 0,0, 0,0, 0, 1,1, 0,0,  0,0,  0,0), 0,1,16'h0000,0,0);
    // flush with R1,R7 busy, wb to R1 and to idle R12
    add(mk(1, 0,0, 0,0, 1,1, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,0);
    add(mk(1, 0,0, 0,0, 1,7, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0002,0,0);
    add(mk(1, 0,0, 0,0, 1,4, 0, 1,0, 1,1,  1,12, 1,0), 0,1,16'h0082,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,0,0);
    // drain with R9 count 2
    add(mk(1, 0,0, 0,0, 1,9, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,0);
    add(mk(1, 0,0, 0,0, 1,9, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0200,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,1), 0,0,16'h0200,0,0);
    add(mk(1, 0,0, 0,0, 1,1, 0, 1,0, 1,9,  0,0,  0,1), 0,1,16'h0200,0,0);
    add(mk(1, 0,0, 0,0, 1,1, 0, 1,0, 1,9,  0,0,  0,1), 0,1,16'h0200,0,0);
    add(mk(1, 0,0, 0,0, 1,1, 0, 1,0, 0,0,  0,0,  0,1), 0,1,16'h0000,1,0);
    add(mk(1, 0,0, 0,0, 1,1, 0, 1,0, 0,0,  0,0,  0,0), 0,1,16'h0000,1,0);
    add(mk(1, 0,0, 0,0, 1,1, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 1,1,  0,0,  0,0), 0,0,16'h0002,0,0);
    // writeback to idle R12: sticky error
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 1,12, 0,0,  0,0), 0,0,16'h0000,0,0);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,0,1);
    add(mk(1, 0,0, 0,0, 1,3, 0, 1,0, 0,0,  0,0,  0,0), 1,0,16'h0000,0,1);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0008,0,1);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 1,3,  0,0,  0,0), 0,0,16'h0008,0,1);
    // drain with all counters already zero: one DRAIN cycle then DRAINED
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,1), 0,0,16'h0000,0,1);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,1), 0,0,16'h0000,0,1);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,1), 0,0,16'h0000,1,1);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,1,1);
    add(mk(0, 0,0, 0,0, 0,0, 0, 1,0, 0,0,  0,0,  0,0), 0,0,16'h0000,0,1);

    do_reset("init");
    exp_sc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      check($sformatf("row%0d can", i),      32'(sb.canReadOut),  32'(vecs[i].can));
      check($sformatf("row%0d stall", i),    32'(sb.stallOut),    32'(vecs[i].stall));
      check($sformatf("row%0d busy", i),     32'(sb.busyMaskOut), 32'(vecs[i].busy));
      check($sformatf("row%0d drained", i),  32'(sb.drainedOut),  32'(vecs[i].drained));
      check($sformatf("row%0d err", i),      32'(sb.wbErrorOut),  32'(vecs[i].err));
      check($sformatf("row%0d stallcyc", i), sb.stallCyclesOut,   32'(exp_sc));
      if (vecs[i].stall) exp_sc++;
    end

    // Reset after error and stall history clears everything.
    do_reset("post");

    // Randomized traffic against the reference model.
    model_reset();
    drain_hold = 1'b0;
    for (int c = 0; c < N_RAND; c++) begin
      if ($urandom_range(0, 29) == 0) drain_hold = !drain_hold;
      s     = idle();
      s.dec = ($urandom_range(0, 3) != 0);
      s.s1v = $urandom_range(0, 1) == 1; s.s1 = 4'($urandom_range(0, 7));
      s.s2v = $urandom_range(0, 1) == 1; s.s2 = 4'($urandom_range(0, 7));
      s.dv  = $urandom_range(0, 2) != 0; s.d  = 4'($urandom_range(0, 7));
      s.sp  = ($urandom_range(0, 7) == 0);
      s.ds  = ($urandom_range(0, 7) != 0);
      s.st  = ($urandom_range(0, 9) == 0);
      s.w0v = ($urandom_range(0, 4) < 2); s.w0 = 4'(pick_wb_reg());
      s.w1v = ($urandom_range(0, 4) < 2); s.w1 = 4'(pick_wb_reg());
      s.fl  = ($urandom_range(0, 49) == 0);
      s.dr  = drain_hold;
      rn    = ($urandom_range(0, 149) != 0);
      @(negedge clk);
      drive(s);
      reset_n = rn;
      #1;
      e_can = model_can(s, rn);
      e_stl = s.dec && !e_can;
      check($sformatf("rnd%0d can", c),      32'(sb.canReadOut),  32'(e_can));
      check($sformatf("rnd%0d stall", c),    32'(sb.stallOut),    32'(e_stl));
      check($sformatf("rnd%0d busy", c),     32'(sb.busyMaskOut), 32'(model_busy()));
      check($sformatf("rnd%0d drained", c),  32'(sb.drainedOut),  32'(m_state == 2));
      check($sformatf("rnd%0d err", c),      32'(sb.wbErrorOut),  32'(m_err));
      check($sformatf("rnd%0d stallcyc", c), sb.stallCyclesOut,   32'(m_sc));
      model_step(s, rn, e_can, e_stl);
    end

    reset_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
